// File: rtl/alu_share_arbiter.sv
// Two-requester front end for one shared combinational ALU: round-robin (or fixed)
// req/gnt arbitration, a single registered response slot and a gated architectural flag register.
module alu_share_arbiter #(
    parameter int WIDTH     = 16,
    parameter int FLAGW     = 6,
    parameter int FIXED_PRI = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] op1_0,
    input  logic [WIDTH-1:0] op1_1,
    input  logic [WIDTH-1:0] op2_0,
    input  logic [WIDTH-1:0] op2_1,
    input  logic [1:0]       func_0,
    input  logic [1:0]       func_1,
    input  logic [1:0]       fen,
    output logic [1:0]       gnt,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [1:0]       alu_func,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [FLAGW-1:0] alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [FLAGW-1:0] rsp_flags,
    output logic [FLAGW-1:0] flags_q
);

    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;
    logic [FLAGW-1:0] r_rsp_flags;
    logic [FLAGW-1:0] r_flags_q;
    logic             r_last;
    logic             w_can_accept;
    logic             w_sel;

    // r_last is the index granted most recently; under contention the other one wins.
    function automatic logic [1:0] pick_grant(input logic [1:0] r, input logic last);
        logic [1:0] g;
        case (r)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11: begin
                if (FIXED_PRI != 0) begin
                    g = 2'b01;
                end else if (last) begin
                    g = 2'b01;
                end else begin
                    g = 2'b10;
                end
            end
            default: g = 2'b00;
        endcase
        return g;
    endfunction

    assign w_can_accept = ~r_rsp_valid | rsp_ready;

    // Combinational grant, suppressed during reset and while the slot cannot take a result.
    always_comb begin
        gnt = 2'b00;
        if (rst_n && w_can_accept) begin
            gnt = pick_grant(req, r_last);
        end else begin
            gnt = 2'b00;
        end
    end

    assign w_sel = gnt[1];

    // Operand mux to the shared ALU; requester 0 drives it when nobody is granted.
    always_comb begin
        alu_op1  = op1_0;
        alu_op2  = op2_0;
        alu_func = func_0;
        if (w_sel) begin
            alu_op1  = op1_1;
            alu_op2  = op2_1;
            alu_func = func_1;
        end else begin
            alu_op1  = op1_0;
            alu_op2  = op2_0;
            alu_func = func_0;
        end
    end

    // Response slot, RR pointer and flag register; a grant reloads the slot even while it is being consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= {WIDTH{1'b0}};
            r_rsp_flags  <= {FLAGW{1'b0}};
            r_flags_q    <= {FLAGW{1'b0}};
            r_last       <= 1'b1;
        end else if (|gnt) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= w_sel;
            r_rsp_result <= alu_result;
            r_rsp_flags  <= alu_flags;
            r_last       <= w_sel;
            if (fen[w_sel]) begin
                r_flags_q <= alu_flags;
            end else begin
                r_flags_q <= r_flags_q;
            end
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end else begin
            r_rsp_valid <= r_rsp_valid;
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign flags_q    = r_flags_q;

endmodule
